aes256_ctr_sched: RTL and testbench
===================================

Name: aes256_ctr_sched

Overview:
- Sequencing controller for the AES-256-CTR engine.
- Runs key expansion on a new key and holds the counter block (nonce || 32-bit block counter).
- Accepts plaintext blocks, drives the iterative cipher core one round per cycle by issuing round-key indices 0..14, then XORs the keystream with the plaintext and presents the ciphertext on a valid/ready output.
- Sits between the host stream interface and the key-expansion and cipher-round datapaths.

Parameters:
NUM_ROUNDS, 14, last round-key index (AES-256: 14; 15 round keys)
CTR_W, 32, width of the incrementing counter field (low bits of counter block)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
key_in  in  256  cipher key
key_valid  in  1  key load request
key_ready  out  1  key accepted when key_valid & key_ready
ke_start  out  1  one-cycle start pulse to key expansion
ke_key  out  256  registered key to key expansion
ke_done  in  1  key expansion finished (single-cycle pulse)
iv_in  in  128  initial counter block
iv_load  in  1  load iv_in into counter register
pt_data  in  128  plaintext block
pt_valid  in  1  plaintext valid
pt_ready  out  1  plaintext accepted when pt_valid & pt_ready
core_load  out  1  one-cycle pulse: core latches core_in
core_in  out  128  counter block to encrypt
core_en  out  1  core performs round rk_idx this cycle
rk_idx  out  4  round-key index to core / key store
core_out  in  128  keystream, valid the cycle after the last core_en
ct_data  out  128  ciphertext (registered)
ct_valid  out  1  ciphertext valid
ct_ready  in  1  downstream accepts
key_ok  out  1  expanded key available
ctr_wrap  out  1  sticky: counter field wrapped
busy  out  1  state not in {IDLE, READY}

Behaviour:
- Reset values:
  - state=IDLE; key_ok=0, ctr_wrap=0.
  - All pulses and valids (ke_start, core_load, core_en, ct_valid) = 0.
  - rk_idx=0; ctr_reg=0; ct_data=0; ke_key=0.
- Reset mid-operation aborts immediately. No output is held over.
- States: IDLE, KEY_EXP, READY, ROUND, CAPTURE, OUTPUT.
- key_ready=1 only in IDLE or READY.
- On key handshake:
  - ke_key<=key_in; key_ok<=0; state->KEY_EXP.
  - ke_start is high for the first KEY_EXP cycle only.
  - KEY_EXP waits for ke_done, then key_ok<=1 and state->READY.
  - ke_done outside KEY_EXP is ignored.
- iv_load is honoured only in IDLE/READY: ctr_reg<=iv_in, ctr_wrap<=0. In any other state it is ignored.
- If a key handshake and iv_load occur in the same cycle, both take effect.
- pt_ready=1 only in READY with key_ok=1 and iv_load=0 (iv_load has priority over a block start).
- Plaintext handshake at edge T:
  - pt latched; core_in<=ctr_reg; core_load=1 during cycle T+1.
  - state->ROUND, rnd=0.
- ROUND, cycles T+1..T+15:
  - core_en=1, rk_idx=rnd; rnd increments each cycle.
  - When rnd==NUM_ROUNDS, state->CAPTURE.
- CAPTURE (T+16): ct_data<=pt^core_out; state->OUTPUT.
- OUTPUT:
  - ct_valid=1 from T+17. ct_data is held stable until ct_ready.
  - On handshake, the low CTR_W bits of ctr_reg increment mod 2^CTR_W; the upper 96 bits are never touched.
  - If the old value was all-ones, ctr_wrap<=1.
  - state->READY.
- Minimum throughput: one block per 18 cycles, since READY lasts at least one cycle.
- key_valid during ROUND/CAPTURE/OUTPUT is not accepted (key_ready=0). The current block completes with the old key.

Decomposition:
- Shared package aes_pkg:
  - state enum type;
  - AES256_NUM_ROUNDS=14, AES_BLK_W=128, AES256_KEY_W=256;
  - CTR field width constant.
- Sub-module aes_ctr_inc: counter-field increment plus wrap detect. The rest stays in one FSM module.

Test Plan:
- Reset, then key 603deb10...0914dff4 with ke_done returned 20 cycles after ke_start -> ke_start is exactly one pulse; key_ok rises the cycle after ke_done; key_ready=0 while in KEY_EXP.
- iv f0f1...feff, pt 6bc1bee2...93172a, reference cipher core -> core_en high for 15 cycles with rk_idx 0..14; ct 601ec313775789a5b7a7f504bbf3d228 valid at T+17.
- Second block ae2d8a57... after the first handshake -> core_in=f0f1...fdff00; ct f443e3ca4d62b59aca84e990cacaf5c5.
- iv low word ffffffff, two blocks -> second core_in low word 00000000; upper 96 bits unchanged; ctr_wrap=1 until the next iv_load.
- ct_ready held low 10 cycles in OUTPUT -> ct_valid and ct_data stable; pt_ready=0; counter unchanged until the handshake.
- rst asserted at round 7 -> next cycle core_en=0, ct_valid=0, key_ok=0; a new key is required before pt_ready rises again.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256-CTR sequencing controller.
// Contents: FSM state enum, AES-256 round/width constants, counter field width.
package aes_pkg;

  localparam int AES256_NUM_ROUNDS = 14;   // last round-key index
  localparam int AES_BLK_W         = 128;
  localparam int AES256_KEY_W      = 256;
  localparam int AES_CTR_W         = 32;    // incrementing low field of the counter block

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXP,
    S_READY,
    S_ROUND,
    S_CAPTURE,
    S_OUTPUT
  } state_e;

endpackage

// File: rtl/aes_ctr_inc.sv
// Counter-field incrementer with wrap detect.
// Ports:
//   ctr      in  current counter field
//   ctr_next out ctr + 1 modulo 2^W
//   wrap     out ctr is all-ones, so this increment wraps to zero
module aes_ctr_inc #(
  parameter int W = 32
) (
  input  logic [W-1:0] ctr,
  output logic [W-1:0] ctr_next,
  output logic         wrap
);

  assign ctr_next = ctr + W'(1);
  assign wrap     = &ctr;

endmodule

// File: rtl/aes256_ctr_sched.sv
// AES-256-CTR sequencing controller.
// Loads a key and starts key expansion, holds the counter block, and for each
// plaintext block drives the iterative cipher core through round keys
// 0..NUM_ROUNDS, then XORs the keystream into the plaintext and presents the
// ciphertext on a valid/ready output.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   key_in/key_valid/key_ready     key load handshake
//   ke_start/ke_key/ke_done        key-expansion engine control
//   iv_in/iv_load                  counter block load (IDLE/READY only)
//   pt_data/pt_valid/pt_ready      plaintext input handshake
//   core_load/core_in/core_en/
//   rk_idx/core_out                cipher-round core control and keystream
//   ct_data/ct_valid/ct_ready      ciphertext output handshake
//   key_ok, ctr_wrap, busy         status
module aes256_ctr_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
  parameter int CTR_W      = AES_CTR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AES256_KEY_W-1:0] key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic                    ke_start,
  output logic [AES256_KEY_W-1:0] ke_key,
  input  logic                    ke_done,
  input  logic [AES_BLK_W-1:0]    iv_in,
  input  logic                    iv_load,
  input  logic [AES_BLK_W-1:0]    pt_data,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  output logic                    core_load,
  output logic [AES_BLK_W-1:0]    core_in,
  output logic                    core_en,
  output logic [3:0]              rk_idx,
  input  logic [AES_BLK_W-1:0]    core_out,
  output logic [AES_BLK_W-1:0]    ct_data,
  output logic                    ct_valid,
  input  logic                    ct_ready,
  output logic                    key_ok,
  output logic                    ctr_wrap,
  output logic                    busy
);

  state_e                 state, state_nxt;
  logic [AES_BLK_W-1:0]   ctr_reg;
  logic [AES_BLK_W-1:0]   pt_reg;
  logic [3:0]             rnd;
  logic                   ke_first;     // first cycle of KEY_EXP
  logic [CTR_W-1:0]       ctr_inc;
  logic                   inc_wrap;
  logic                   key_hs, pt_hs, out_hs, iv_ok;

  assign key_hs = key_valid & key_ready;
  assign pt_hs  = pt_valid & pt_ready;
  assign out_hs = ct_valid & ct_ready;
  // key_ready marks exactly the IDLE/READY states where the IV may be reloaded
  assign iv_ok  = iv_load & key_ready;
  assign rk_idx = core_en ? rnd : 4'd0;

  aes_ctr_inc #(.W(CTR_W)) u_inc (
    .ctr      (ctr_reg[CTR_W-1:0]),
    .ctr_next (ctr_inc),
    .wrap     (inc_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    pt_ready  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    ke_start  = 1'b0;
    ct_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_valid) state_nxt = S_KEY_EXP;
      end
      S_KEY_EXP: begin
        ke_start = ke_first;
        if (ke_done) state_nxt = S_READY;
      end
      S_READY: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        // A pending key load wins over a block start so a block never
        // starts against a key that is about to be replaced.
        pt_ready  = key_ok & ~iv_load & ~key_valid;
        if (key_valid)     state_nxt = S_KEY_EXP;
        else if (pt_hs)    state_nxt = S_ROUND;
      end
      S_ROUND: begin
        core_en   = 1'b1;
        core_load = (rnd == 4'd0);
        if (rnd == 4'(NUM_ROUNDS)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        ct_valid = 1'b1;
        if (ct_ready) state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ke_first <= 1'b0;
      ke_key   <= '0;
      key_ok   <= 1'b0;
      ctr_reg  <= '0;
      ctr_wrap <= 1'b0;
      pt_reg   <= '0;
      core_in  <= '0;
      rnd      <= '0;
      ct_data  <= '0;
    end else begin
      ke_first <= key_hs;
      if (key_hs) begin
        ke_key <= key_in;
        key_ok <= 1'b0;
      end else if (state == S_KEY_EXP && ke_done) begin
        key_ok <= 1'b1;
      end

      if (iv_ok) begin
        ctr_reg  <= iv_in;
        ctr_wrap <= 1'b0;
      end else if (out_hs) begin
        ctr_reg[CTR_W-1:0] <= ctr_inc;
        if (inc_wrap) ctr_wrap <= 1'b1;
      end

      if (pt_hs) begin
        pt_reg  <= pt_data;
        core_in <= ctr_reg;
        rnd     <= '0;
      end else if (core_en) begin
        rnd <= rnd + 4'd1;
      end

      // keystream is valid in the cycle after the last round
      if (state == S_CAPTURE) ct_data <= pt_reg ^ core_out;
    end
  end

endmodule

// File: tb/tb_aes256_ctr_sched.sv
module tb_aes256_ctr_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic         key_valid, key_ready, ke_start, ke_done;
  logic [255:0] ke_key;
  logic [127:0] iv_in, pt_data, core_in, core_out, ct_data;
  logic         iv_load, pt_valid, pt_ready, core_load, core_en;
  logic [3:0]   rk_idx;
  logic         ct_valid, ct_ready, key_ok, ctr_wrap, busy;

  aes256_ctr_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .ke_start(ke_start), .ke_key(ke_key),
    .ke_done(ke_done), .iv_in(iv_in), .iv_load(iv_load),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .core_load(core_load), .core_in(core_in), .core_en(core_en),
    .rk_idx(rk_idx), .core_out(core_out), .ct_data(ct_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .key_ok(key_ok),
    .ctr_wrap(ctr_wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] PT0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT0  = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] PT1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1  = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] PT2  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT2  = 128'h2b0930daa23de94ce87017ba2d84988d;
  localparam logic [127:0] PT3  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT3  = 128'hdfc9c58db67aada613c2dd08457941a6;
  localparam logic [127:0] IVW  = 128'h00112233445566778899aabbffffffff;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  // Reference cipher core: keystream for the NIST counter blocks is pt^ct of
  // the published vectors; any other block gets a fixed scramble.
  function automatic logic [127:0] ks(input logic [127:0] blk);
    case (blk)
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: ks = PT0 ^ CT0;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: ks = PT1 ^ CT1;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01: ks = PT2 ^ CT2;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02: ks = PT3 ^ CT3;
      default: ks = blk ^ {4{32'h9e3779b9}};
    endcase
  endfunction

  // Core model: keystream appears only in the cycle after round 14.
  logic [127:0] blk_m = '0;
  logic         last_m = 1'b0;
  always @(posedge clk) begin
    if (core_load === 1'b1) blk_m <= core_in;
    last_m <= (core_en === 1'b1) && (rk_idx == 4'd14);
  end
  assign core_out = last_m ? ks(blk_m) : JUNK;

  int ke_pulses = 0;
  always @(posedge clk) if (ke_start === 1'b1) ke_pulses <= ke_pulses + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ci;
    logic [127:0] ct;
    bit           stall;
    bit           poke;
  } vec_t;

  vec_t tv[6];

  task automatic load_key(input logic [255:0] k, input bit with_iv, input logic [127:0] iv);
    int  p0 = ke_pulses;
    bit  hold_ok = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b1; key_in = k;
    if (with_iv) begin iv_load = 1'b1; iv_in = iv; end
    @(negedge clk);
    chk("key_ready_idle", key_ready, 1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0; iv_load = 1'b0; key_in = ~k;
    @(negedge clk);
    chk("ke_start_first", ke_start, 1'b1);
    chk("ke_key", ke_key, k);
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (key_ready !== 1'b0 || key_ok !== 1'b0 || busy !== 1'b1 || ke_start !== 1'b0) hold_ok = 1'b0;
    end
    chk("key_exp_hold", hold_ok, 1'b1);
    @(posedge clk); #1 ke_done = 1'b1;
    @(negedge clk);
    chk("key_ok_before_done", key_ok, 1'b0);
    @(posedge clk); #1 ke_done = 1'b0;
    @(negedge clk);
    chk("key_ok_after_done", key_ok, 1'b1);
    chk("key_ready_ready", {key_ready, busy}, 2'b10);
    chk("ke_start_count", 32'(ke_pulses - p0), 32'd1);
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(posedge clk); #1;
    iv_load = 1'b1; iv_in = v;
    @(negedge clk);
    chk("iv_prio_pt_ready", pt_ready, 1'b0);
    @(posedge clk); #1 iv_load = 1'b0;
  endtask

  task automatic run_block(input vec_t v);
    int n = 0;
    bit seq_ok = 1'b1;
    bit stall_ok = 1'b1;
    @(posedge clk); #1;
    pt_valid = 1'b1; pt_data = v.pt;
    @(negedge clk);
    while (pt_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      chk("pt_ready_timeout", 1'b0, 1'b1);
      pt_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pt_valid = 1'b0; pt_data = ~v.pt;
    @(negedge clk);
    chk("core_load", core_load, 1'b1);
    chk("core_in", core_in, v.ci);
    for (int r = 0; r <= 14; r++) begin
      if (r > 0) @(negedge clk);
      if (core_en !== 1'b1 || rk_idx !== 4'(r) || (r > 0 && core_load !== 1'b0) ||
          ct_valid !== 1'b0 || key_ready !== 1'b0 || pt_ready !== 1'b0 || busy !== 1'b1)
        seq_ok = 1'b0;
      if (v.poke && r == 5) begin
        iv_load = 1'b1; iv_in = JUNK; ke_done = 1'b1; key_valid = 1'b1; key_in = {2{JUNK}};
      end
      if (v.poke && r == 6) begin
        iv_load = 1'b0; ke_done = 1'b0; key_valid = 1'b0;
      end
    end
    chk("round_seq", seq_ok, 1'b1);
    @(negedge clk);
    chk("capture_cycle", {core_en, ct_valid}, 2'b00);
    @(negedge clk);
    chk("ct_valid_t17", ct_valid, 1'b1);
    chk("ct_data", ct_data, v.ct);
    chk("pt_ready_output", pt_ready, 1'b0);
    if (v.stall) begin
      repeat (10) begin
        @(negedge clk);
        if (ct_valid !== 1'b1 || ct_data !== v.ct || pt_ready !== 1'b0) stall_ok = 1'b0;
      end
      chk("stall_hold", stall_ok, 1'b1);
    end
    ct_ready = 1'b1;
    @(posedge clk); #1 ct_ready = 1'b0;
    @(negedge clk);
    chk("after_out_hs", {ct_valid, busy}, 2'b00);
  endtask

  initial begin
    int n;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; ke_done = 1'b0;
    iv_in = '0; iv_load = 1'b0; pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b0;

    tv[0] = '{pt: PT0, ci: IV,                                    ct: CT0, stall: 0, poke: 0};
    tv[1] = '{pt: PT1, ci: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, ct: CT1, stall: 0, poke: 1};
    tv[2] = '{pt: PT2, ci: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01, ct: CT2, stall: 1, poke: 0};
    tv[3] = '{pt: PT3, ci: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02, ct: CT3, stall: 0, poke: 0};
    tv[4] = '{pt: PT0, ci: IVW, ct: PT0 ^ (IVW ^ {4{32'h9e3779b9}}), stall: 0, poke: 0};
    tv[5] = '{pt: PT1, ci: {IVW[127:32], 32'h0},
              ct: PT1 ^ ({IVW[127:32], 32'h0} ^ {4{32'h9e3779b9}}), stall: 0, poke: 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flags", {key_ok, ctr_wrap, ct_valid, core_en, core_load, ke_start, busy}, 7'b0);
    chk("rst_rk_idx", rk_idx, 4'd0);
    chk("rst_ct_data", ct_data, 128'h0);
    chk("rst_ke_key", ke_key, 256'h0);
    chk("rst_ready", {key_ready, pt_ready}, 2'b10);

    // key and IV loaded in the same cycle
    load_key(KEY, 1'b1, IV);

    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        load_iv(IVW);
        chk("wrap_clear_on_iv", ctr_wrap, 1'b0);
      end
      run_block(tv[i]);
      if (i == 4) chk("wrap_set", ctr_wrap, 1'b1);
      if (i == 5) chk("wrap_sticky", ctr_wrap, 1'b1);
    end
    load_iv(IV);
    chk("wrap_clear_iv2", ctr_wrap, 1'b0);

    // reset at round 7
    @(posedge clk); #1 pt_valid = 1'b1; pt_data = PT0;
    @(negedge clk);
    n = 0;
    while (pt_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1 pt_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(core_en === 1'b1 && rk_idx == 4'd7) && n < 40) begin @(negedge clk); n++; end
    chk("reach_round7", (n < 40), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flags", {core_en, ct_valid, key_ok, busy}, 4'b0);
    chk("rst_mid_rk_idx", rk_idx, 4'd0);
    ke_done = 1'b1;
    @(negedge clk);
    ke_done = 1'b0;
    @(negedge clk);
    chk("ke_done_idle_ignored", {key_ok, busy}, 2'b00);
    pt_valid = 1'b1; pt_data = PT0;
    n = 0;
    repeat (5) begin @(negedge clk); if (pt_ready !== 1'b0) n++; end
    chk("no_pt_without_key", n, 0);
    load_key(KEY, 1'b0, '0);
    chk("pt_ready_after_rekey", pt_ready, 1'b1);
    pt_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
